ddr_word_serializer: RTL and testbench

Parametrised word-to-serial transmitter with a DDR output stage. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out on a single pin, two bits per clock in DDR mode or one bit per clock in SDR mode. Between words the line carries a programmable idle pair. It sits between a link framer and the pad, and replaces the fixed 2-bit DDR serializer on multi-bit links.

---
 rtl/ddr_word_serializer_pkg.sv | 13 +
 rtl/ddr_word_serializer_out_stage.sv | 35 +++
 rtl/ddr_word_serializer.sv | 100 ++++++++++
 tb/tb_ddr_word_serializer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_word_serializer_pkg.sv
// Shared types and helpers for the word serializer and its DDR output stage.
package ser_pkg;

    typedef enum logic {SER_DDR, SER_SDR} ser_mode_e;

    typedef enum logic {ST_IDLE, ST_SHIFT} ser_state_e;

    // Number of output units (one per clock) needed to send one word.
    function automatic int units_per_word(input ser_mode_e mode, input int width);
        return (mode == SER_SDR) ? width : width / 2;
    endfunction

endpackage

// File: rtl/ddr_word_serializer_out_stage.sv
// XOR-encoded DDR output flop pair: hi is shown in the high phase, lo in the low phase.
module ddr_out_stage (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hi_i,
    input  logic lo_i,
    output logic data_o
);

    logic p;
    logic n;
    logic nn;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p <= 1'b0;
            n <= 1'b0;
        end else begin
            p <= hi_i ^ n;
            n <= lo_i ^ hi_i ^ n;
        end
    end

    // nn follows n half a cycle later, so p ^ nn flips from hi to lo at the falling edge.
    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nn <= 1'b0;
        end else begin
            nn <= n;
        end
    end

    assign data_o = p ^ nn;

endmodule

// File: rtl/ddr_word_serializer.sv
// Word-to-serial transmitter: valid/ready intake, unit shifter and DDR/SDR output on one pin.
module ddr_word_serializer
    import ser_pkg::*;
#(
    parameter int         WIDTH     = 8,
    parameter bit         LSB_FIRST = 1'b1,
    parameter logic [1:0] IDLE_PAIR = 2'b00
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             bypass_i,
    output logic             data_o,
    output logic             sync_o
);

    localparam int CNT_W = $clog2(WIDTH);

    ser_state_e       state;
    ser_mode_e        mode;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0] cnt;
    logic             first;
    logic             sync_r;
    logic             accept;
    logic             hi;
    logic             lo;
    ser_mode_e        mode_in;

    assign mode_in = ser_mode_e'(bypass_i);
    assign ready_o = !rst_i && (state == ST_IDLE || cnt == '0);
    assign accept  = valid_i && ready_o;

    // The earlier bit of a unit is always placed in the high phase.
    always_comb begin
        hi = IDLE_PAIR[1];
        lo = IDLE_PAIR[0];
        if (state == ST_SHIFT) begin
            if (LSB_FIRST) begin
                hi = shreg[0];
                lo = (mode == SER_SDR) ? shreg[0] : shreg[1];
            end else begin
                hi = shreg[WIDTH-1];
                lo = (mode == SER_SDR) ? shreg[WIDTH-1] : shreg[WIDTH-2];
            end
        end
    end

    always_comb begin
        shreg_next = shreg;
        if (LSB_FIRST) begin
            shreg_next = (mode == SER_SDR) ? (shreg >> 1) : (shreg >> 2);
        end else begin
            shreg_next = (mode == SER_SDR) ? (shreg << 1) : (shreg << 2);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            mode   <= SER_DDR;
            shreg  <= '0;
            cnt    <= '0;
            first  <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            sync_r <= (state == ST_SHIFT) && first;
            if (accept) begin
                // A back-to-back accept coincides with the last unit of the previous word.
                shreg <= data_i;
                mode  <= mode_in;
                cnt   <= CNT_W'(units_per_word(mode_in, WIDTH) - 1);
                state <= ST_SHIFT;
                first <= 1'b1;
            end else if (state == ST_SHIFT) begin
                shreg <= shreg_next;
                first <= 1'b0;
                if (cnt == '0) begin
                    state <= ST_IDLE;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

    assign sync_o = sync_r;

    ddr_out_stage u_out (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hi_i  (hi),
        .lo_i  (lo),
        .data_o(data_o)
    );

endmodule

// File: tb/tb_ddr_word_serializer.sv
// Directed bench: LSB-first, MSB-first and non-zero idle-pair instances share one stimulus.
module tb_ddr_word_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       bypass;
    logic       ready_l, ready_m, ready_i;
    logic       dout_l, dout_m, dout_i;
    logic       sync_l, sync_m, sync_i;

    int checks = 0;
    int errors = 0;

    logic hi_l [0:15];
    logic lo_l [0:15];
    logic hi_m [0:15];
    logic lo_m [0:15];
    logic sy   [0:15];
    logic rd   [0:15];

    ddr_word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_PAIR(2'b00)) dut_l (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready_l),
        .bypass_i(bypass), .data_o(dout_l), .sync_o(sync_l)
    );

    ddr_word_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_PAIR(2'b00)) dut_m (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready_m),
        .bypass_i(bypass), .data_o(dout_m), .sync_o(sync_m)
    );

    ddr_word_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_PAIR(2'b10)) dut_i (
        .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid), .ready_o(ready_i),
        .bypass_i(bypass), .data_o(dout_i), .sync_o(sync_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one word so that it is accepted at the next rising edge; returns 1 time unit after it.
    task automatic start_word(input logic [7:0] w, input logic byp);
        @(negedge clk);
        data   = w;
        valid  = 1'b1;
        bypass = byp;
        @(posedge clk);
        #1;
    endtask

    // Sample n output cycles, starting at the next rising edge.
    task automatic collect(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #2;
            hi_l[c] = dout_l;
            hi_m[c] = dout_m;
            sy[c]   = sync_l;
            rd[c]   = ready_l;
            #5;
            lo_l[c] = dout_l;
            lo_m[c] = dout_m;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; data = 8'h00; bypass = 1'b0;
        #1;
        checks++;
        if (dout_l !== 1'b0 || ready_l !== 1'b0 || sync_l !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold data=%b ready=%b sync=%b required 0 0 0", dout_l, ready_l, sync_l);
        end
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (dout_i !== 1'b0 || ready_i !== 1'b0) begin
            errors++;
            $display("FAIL reset_edges data=%b ready=%b required 0 0", dout_i, ready_i);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ready_l !== 1'b1 || dout_l !== 1'b0 || dout_i !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready=%b data=%b idle_dut=%b required 1 0 0", ready_l, dout_l, dout_i);
        end
        @(posedge clk);
        #2;
        checks++;
        if (dout_l !== 1'b0 || dout_i !== 1'b1) begin
            errors++;
            $display("FAIL idle_high data=%b idle_dut=%b required 0 1", dout_l, dout_i);
        end
        @(negedge clk);
        #2;
        checks++;
        if (dout_l !== 1'b0 || dout_i !== 1'b0) begin
            errors++;
            $display("FAIL idle_low data=%b idle_dut=%b required 0 0", dout_l, dout_i);
        end
    endtask

    task automatic test_ddr();
        logic [9:0] exp;
        logic [4:0] exp_sy;
        logic [4:0] exp_rd;
        exp    = 10'b10100101_00;
        exp_sy = 5'b10000;
        exp_rd = 5'b00111;
        start_word(8'hA5, 1'b0);
        valid = 1'b0;
        checks++;
        if (ready_l !== 1'b0) begin
            errors++;
            $display("FAIL ddr_ready_first got=%b required 0", ready_l);
        end
        collect(5);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (hi_l[c] !== exp[9-2*c] || lo_l[c] !== exp[8-2*c]) begin
                errors++;
                $display("FAIL ddr_lsb_pair%0d got=%b%b required %b%b", c, hi_l[c], lo_l[c], exp[9-2*c], exp[8-2*c]);
            end
            checks++;
            if (hi_m[c] !== exp[9-2*c] || lo_m[c] !== exp[8-2*c]) begin
                errors++;
                $display("FAIL ddr_msb_pair%0d got=%b%b required %b%b", c, hi_m[c], lo_m[c], exp[9-2*c], exp[8-2*c]);
            end
            checks++;
            if (sy[c] !== exp_sy[4-c] || rd[c] !== exp_rd[4-c]) begin
                errors++;
                $display("FAIL ddr_sync_ready%0d got=%b%b required %b%b", c, sy[c], rd[c], exp_sy[4-c], exp_rd[4-c]);
            end
        end
    endtask

    task automatic test_bit_order();
        logic [7:0] exp_l;
        logic [7:0] exp_m;
        exp_l = 8'b01001000;
        exp_m = 8'b00010010;
        start_word(8'h12, 1'b0);
        valid = 1'b0;
        collect(4);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (hi_l[c] !== exp_l[7-2*c] || lo_l[c] !== exp_l[6-2*c]) begin
                errors++;
                $display("FAIL order_lsb_pair%0d got=%b%b required %b%b", c, hi_l[c], lo_l[c], exp_l[7-2*c], exp_l[6-2*c]);
            end
            checks++;
            if (hi_m[c] !== exp_m[7-2*c] || lo_m[c] !== exp_m[6-2*c]) begin
                errors++;
                $display("FAIL order_msb_pair%0d got=%b%b required %b%b", c, hi_m[c], lo_m[c], exp_m[7-2*c], exp_m[6-2*c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp;
        logic [8:0]  exp_sy;
        exp    = 18'b10100101_00111100_00;
        exp_sy = 9'b100010000;
        start_word(8'hA5, 1'b0);
        data = 8'h3C;
        fork
            collect(9);
            begin
                repeat (4) @(posedge clk);
                #1 valid = 1'b0;
            end
        join
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (hi_l[c] !== exp[17-2*c] || lo_l[c] !== exp[16-2*c] || sy[c] !== exp_sy[8-c]) begin
                errors++;
                $display("FAIL b2b_cycle%0d got=%b%b sync=%b required %b%b sync=%b", c, hi_l[c], lo_l[c], sy[c],
                         exp[17-2*c], exp[16-2*c], exp_sy[8-c]);
            end
        end
    endtask

    task automatic test_sdr();
        logic [8:0] exp;
        exp = 9'b10100101_0;
        start_word(8'hA5, 1'b1);
        valid  = 1'b0;
        bypass = 1'b0;
        collect(9);
        for (int c = 0; c < 9; c++) begin
            checks++;
            if (hi_l[c] !== exp[8-c] || lo_l[c] !== exp[8-c] || sy[c] !== (c == 0)) begin
                errors++;
                $display("FAIL sdr_cycle%0d got=%b%b sync=%b required %b%b sync=%b", c, hi_l[c], lo_l[c], sy[c],
                         exp[8-c], exp[8-c], (c == 0));
            end
        end
    endtask

    task automatic test_bypass_switch();
        logic [12:0] exp;
        logic [12:0] exp_sy;
        exp    = 13'b1111_1111_0000_0;
        exp_sy = 13'b1000_1000_0000_0;
        start_word(8'hFF, 1'b0);
        data = 8'h0F;
        fork
            collect(13);
            begin
                @(posedge clk);
                #1 bypass = 1'b1;
                repeat (3) @(posedge clk);
                #1 valid = 1'b0;
            end
        join
        bypass = 1'b0;
        for (int c = 0; c < 13; c++) begin
            checks++;
            if (hi_l[c] !== exp[12-c] || lo_l[c] !== exp[12-c] || sy[c] !== exp_sy[12-c]) begin
                errors++;
                $display("FAIL bypass_cycle%0d got=%b%b sync=%b required %b%b sync=%b", c, hi_l[c], lo_l[c], sy[c],
                         exp[12-c], exp[12-c], exp_sy[12-c]);
            end
        end
        checks++;
        if (rd[9] !== 1'b0 || rd[10] !== 1'b1) begin
            errors++;
            $display("FAIL bypass_ready got=%b%b required 01", rd[9], rd[10]);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [9:0] exp;
        exp = 10'b00111100_00;
        start_word(8'hA5, 1'b0);
        valid = 1'b0;
        collect(1);
        @(posedge clk);
        #2;
        checks++;
        if (dout_l !== 1'b1) begin
            errors++;
            $display("FAIL mid_word_before got=%b required 1", dout_l);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (dout_l !== 1'b0 || ready_l !== 1'b0 || sync_l !== 1'b0) begin
            errors++;
            $display("FAIL mid_word_async data=%b ready=%b sync=%b required 0 0 0", dout_l, ready_l, sync_l);
        end
        @(posedge clk);
        #2;
        checks++;
        if (dout_l !== 1'b0) begin
            errors++;
            $display("FAIL mid_word_held got=%b required 0", dout_l);
        end
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (ready_l !== 1'b1) begin
            errors++;
            $display("FAIL mid_word_release ready=%b required 1", ready_l);
        end
        start_word(8'h3C, 1'b0);
        valid = 1'b0;
        collect(5);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (hi_l[c] !== exp[9-2*c] || lo_l[c] !== exp[8-2*c] || sy[c] !== (c == 0)) begin
                errors++;
                $display("FAIL after_reset_pair%0d got=%b%b sync=%b required %b%b sync=%b", c, hi_l[c], lo_l[c], sy[c],
                         exp[9-2*c], exp[8-2*c], (c == 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_ddr();
        test_bit_order();
        test_back_to_back();
        test_sdr();
        test_bypass_switch();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
